// File: rtl/mau_pkg.sv
// ----------------------------------------------------------------------------
// mau_pkg
//   Shared definitions for the memory access unit.
//   - SZ_B/SZ_H/SZ_W/SZ_D : access size encodings (1, 2, 4, 8 bytes)
//   - state_e             : load/store FSM states
//   - lane_mask()         : byte-lane enable pattern for an access of a given
//                           size at a given byte offset within an NB-byte word
// ----------------------------------------------------------------------------
package mau_pkg;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_D = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ISSUE = 2'b01,
        ST_WAIT  = 2'b10,
        ST_RESP  = 2'b11
    } state_e;

    // ((1 << bytes) - 1) << off, clipped to the nb lanes that exist.
    function automatic logic [7:0] lane_mask(input logic [1:0] size,
                                             input logic [2:0] off,
                                             input int unsigned nb);
        logic [7:0] m;
        m = (size == SZ_D) ? 8'hFF : 8'((9'd1 << (4'd1 << size)) - 9'd1);
        m = m << off;
        if (nb < 8) begin
            m = m & 8'((9'd1 << nb) - 9'd1);
        end
        return m;
    endfunction

endpackage

// File: rtl/mem_access_unit_load_extend.sv
// ----------------------------------------------------------------------------
// load_extend
//   Combinational load alignment: shifts the RAM word right so the addressed
//   bytes land at bit 0, then sign- or zero-extends from the access width.
//   Ports:
//     rdata_i  raw RAM word
//     off_i    byte offset of the access inside the word
//     size_i   access size encoding (SZ_B..SZ_D)
//     uns_i    1 = zero-extend, 0 = sign-extend
//     data_o   right-aligned, extended load value
// ----------------------------------------------------------------------------
module load_extend
    import mau_pkg::*;
#(
    parameter int DATA_BITS = 32
) (
    input  logic [DATA_BITS-1:0]           rdata_i,
    input  logic [$clog2(DATA_BITS/8)-1:0] off_i,
    input  logic [1:0]                     size_i,
    input  logic                           uns_i,
    output logic [DATA_BITS-1:0]           data_o
);

    logic [DATA_BITS-1:0] shifted;
    logic [DATA_BITS-1:0] mask;
    logic [DATA_BITS-1:0] msb;
    logic                 sign;

    always_comb begin
        shifted = rdata_i >> {off_i, 3'b000};
        case (size_i)
            SZ_B:    mask = DATA_BITS'(8'hFF);
            SZ_H:    mask = DATA_BITS'(16'hFFFF);
            SZ_W:    mask = DATA_BITS'(32'hFFFF_FFFF);
            default: mask = {DATA_BITS{1'b1}};
        endcase
        // Top bit of the field selects the sign; everything above it is filled.
        msb    = mask & ~(mask >> 1);
        sign   = |(shifted & msb);
        data_o = (shifted & mask) | ((sign && !uns_i) ? ~mask : {DATA_BITS{1'b0}});
    end

endmodule

// File: rtl/mem_access_unit.sv
// ----------------------------------------------------------------------------
// mem_access_unit
//   Registered load/store path between the EX/MEM stage and a synchronous
//   data RAM. One request in flight; misaligned or oversized accesses are
//   answered with an error without touching the RAM.
//   Ports:
//     clk, rst_n            clock, synchronous active-low reset
//     req_valid/req_ready   request handshake (ready only in IDLE)
//     req_we/size/unsigned  store flag, size code, load zero-extend flag
//     req_addr/req_wdata    byte address, right-aligned store data
//     ram_en/we/addr/sel    RAM strobe, write enable, word address, lanes
//     ram_wdata/ram_rdata   lane-shifted store data, raw read data
//     rsp_valid/rsp_ready   response handshake
//     rsp_rdata/rsp_err     extended load data, error flag
// ----------------------------------------------------------------------------
module mem_access_unit
    import mau_pkg::*;
#(
    parameter int ADDR_BITS  = 32,
    parameter int DATA_BITS  = 32,
    parameter int RD_LATENCY = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_we,
    input  logic [1:0]             req_size,
    input  logic                   req_unsigned,
    input  logic [31:0]            req_addr,
    input  logic [DATA_BITS-1:0]   req_wdata,
    output logic                   ram_en,
    output logic                   ram_we,
    output logic [ADDR_BITS-1:0]   ram_addr,
    output logic [DATA_BITS/8-1:0] ram_sel,
    output logic [DATA_BITS-1:0]   ram_wdata,
    input  logic [DATA_BITS-1:0]   ram_rdata,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [DATA_BITS-1:0]   rsp_rdata,
    output logic                   rsp_err
);

    localparam int NB    = DATA_BITS / 8;
    localparam int OFF_W = $clog2(NB);
    localparam int CNT_W = $clog2(RD_LATENCY + 1);

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 we_q, we_d;
    logic [1:0]           size_q, size_d;
    logic                 uns_q, uns_d;
    logic [OFF_W-1:0]     off_q, off_d;

    logic                 ram_en_q, ram_en_d;
    logic                 ram_we_q, ram_we_d;
    logic [ADDR_BITS-1:0] ram_addr_q, ram_addr_d;
    logic [NB-1:0]        ram_sel_q, ram_sel_d;
    logic [DATA_BITS-1:0] ram_wdata_q, ram_wdata_d;
    logic                 rsp_valid_q, rsp_valid_d;
    logic [DATA_BITS-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                 rsp_err_q, rsp_err_d;

    logic [OFF_W-1:0]     req_off;
    logic [3:0]           nbytes;
    logic                 size_bad;
    logic                 misaligned;
    logic [31:0]          word_addr;
    logic [DATA_BITS-1:0] ext_data;

    load_extend #(
        .DATA_BITS (DATA_BITS)
    ) u_load_extend (
        .rdata_i (ram_rdata),
        .off_i   (off_q),
        .size_i  (size_q),
        .uns_i   (uns_q),
        .data_o  (ext_data)
    );

    // Request decode
    always_comb begin
        req_off    = req_addr[OFF_W-1:0];
        nbytes     = 4'd1 << req_size;
        size_bad   = (nbytes > 4'(NB));
        misaligned = |(req_off & OFF_W'(nbytes - 4'd1));
        word_addr  = req_addr >> OFF_W;
    end

    assign req_ready = (state_q == ST_IDLE);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        size_d      = size_q;
        uns_d       = uns_q;
        off_d       = off_q;
        ram_addr_d  = ram_addr_q;
        ram_sel_d   = ram_sel_q;
        ram_wdata_d = ram_wdata_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;

        case (state_q)
            ST_IDLE: begin
                if (req_valid && req_ready) begin
                    we_d        = req_we;
                    size_d      = req_size;
                    uns_d       = req_unsigned;
                    off_d       = req_off;
                    rsp_rdata_d = '0;
                    rsp_err_d   = size_bad || misaligned;
                    if (size_bad || misaligned) begin
                        state_d = ST_RESP;
                    end else begin
                        state_d     = ST_ISSUE;
                        ram_addr_d  = ADDR_BITS'(word_addr);
                        ram_sel_d   = NB'(lane_mask(req_size, 3'(req_off), NB));
                        ram_wdata_d = req_wdata << {req_off, 3'b000};
                    end
                end
            end
            ST_ISSUE: begin
                if (we_q) begin
                    state_d = ST_RESP;
                end else begin
                    state_d = ST_WAIT;
                    cnt_d   = CNT_W'(RD_LATENCY - 1);
                end
            end
            ST_WAIT: begin
                // The RAM word is valid on the last WAIT cycle only.
                if (cnt_q == '0) begin
                    rsp_rdata_d = ext_data;
                    state_d     = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Strobes are derived from the next state so they register in step with it.
        ram_en_d    = (state_d == ST_ISSUE);
        ram_we_d    = (state_d == ST_ISSUE) && we_d;
        rsp_valid_d = (state_d == ST_RESP);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            size_q      <= SZ_B;
            uns_q       <= 1'b0;
            off_q       <= '0;
            ram_en_q    <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_sel_q   <= '0;
            ram_wdata_q <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            size_q      <= size_d;
            uns_q       <= uns_d;
            off_q       <= off_d;
            ram_en_q    <= ram_en_d;
            ram_we_q    <= ram_we_d;
            ram_addr_q  <= ram_addr_d;
            ram_sel_q   <= ram_sel_d;
            ram_wdata_q <= ram_wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign ram_en    = ram_en_q;
    assign ram_we    = ram_we_q;
    assign ram_addr  = ram_addr_q;
    assign ram_sel   = ram_sel_q;
    assign ram_wdata = ram_wdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

    localparam int RL   = 2;
    localparam int RL64 = 1;

    typedef struct packed {
        logic        we;
        logic [31:0] waddr;
        logic [7:0]  sel;
        logic [63:0] wdata;
    } ram_exp_t;

    typedef struct packed {
        logic [63:0] rdata;
        logic        err;
    } rsp_exp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // 32-bit unit, RD_LATENCY = 2
    logic        req_valid, req_ready, req_we, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        ram_en, ram_we;
    logic [31:0] ram_addr, ram_wdata, ram_rdata;
    logic [3:0]  ram_sel;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_rdata;

    // 64-bit unit, RD_LATENCY = 1
    logic        b_req_valid, b_req_ready, b_req_we, b_req_unsigned;
    logic [1:0]  b_req_size;
    logic [31:0] b_req_addr;
    logic [63:0] b_req_wdata;
    logic        b_ram_en, b_ram_we;
    logic [31:0] b_ram_addr;
    logic [7:0]  b_ram_sel;
    logic [63:0] b_ram_wdata, b_ram_rdata;
    logic        b_rsp_valid, b_rsp_ready, b_rsp_err;
    logic [63:0] b_rsp_rdata;

    mem_access_unit #(.ADDR_BITS(32), .DATA_BITS(32), .RD_LATENCY(RL)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .ram_en(ram_en), .ram_we(ram_we),
        .ram_addr(ram_addr), .ram_sel(ram_sel), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    mem_access_unit #(.ADDR_BITS(32), .DATA_BITS(64), .RD_LATENCY(RL64)) dut64 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(b_req_we),
        .req_size(b_req_size), .req_unsigned(b_req_unsigned), .req_addr(b_req_addr),
        .req_wdata(b_req_wdata), .ram_en(b_ram_en), .ram_we(b_ram_we),
        .ram_addr(b_ram_addr), .ram_sel(b_ram_sel), .ram_wdata(b_ram_wdata),
        .ram_rdata(b_ram_rdata), .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready),
        .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err)
    );

    int n_checks = 0;
    int n_fail   = 0;
    logic hold_rsp = 1'b0;

    ram_exp_t ramq[$];
    rsp_exp_t rspq[$];

    logic [7:0] ram_bytes   [int];
    logic [7:0] ram64_bytes [int];
    logic [7:0] refmem      [int];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] init_byte(input int a);
        return 8'(a * 37 + (a >>> 5) * 11 + 91);
    endfunction

    function automatic logic [7:0] get_ram(input int a);
        if (ram_bytes.exists(a)) return ram_bytes[a];
        return init_byte(a);
    endfunction

    function automatic logic [7:0] get_ram64(input int a);
        if (ram64_bytes.exists(a)) return ram64_bytes[a];
        return init_byte(a);
    endfunction

    function automatic logic [7:0] get_ref(input int a);
        if (refmem.exists(a)) return refmem[a];
        return init_byte(a);
    endfunction

    // Behavioural RAM for the 32-bit unit: byte storage, RL-cycle read pipe.
    logic [31:0] rpipe [RL];
    assign ram_rdata = rpipe[RL-1];
    initial begin
        forever begin
            @(posedge clk);
            for (int i = RL - 1; i > 0; i--) rpipe[i] <= rpipe[i-1];
            if (ram_en && ram_we) begin
                for (int i = 0; i < 4; i++)
                    if (ram_sel[i]) ram_bytes[int'(ram_addr) * 4 + i] = ram_wdata[8*i +: 8];
            end else if (ram_en) begin
                logic [31:0] w;
                for (int i = 0; i < 4; i++) w[8*i +: 8] = get_ram(int'(ram_addr) * 4 + i);
                rpipe[0] <= w;
            end
        end
    end

    // Behavioural RAM for the 64-bit unit.
    logic [63:0] rpipe64 [RL64];
    assign b_ram_rdata = rpipe64[RL64-1];
    initial begin
        forever begin
            @(posedge clk);
            if (b_ram_en && b_ram_we) begin
                for (int i = 0; i < 8; i++)
                    if (b_ram_sel[i]) ram64_bytes[int'(b_ram_addr) * 8 + i] = b_ram_wdata[8*i +: 8];
            end else if (b_ram_en) begin
                logic [63:0] w;
                for (int i = 0; i < 8; i++) w[8*i +: 8] = get_ram64(int'(b_ram_addr) * 8 + i);
                rpipe64[0] <= w;
            end
        end
    end

    // Reference model for the 32-bit unit: byte-addressed memory, plain arithmetic.
    task automatic model32(input logic we, input logic [1:0] size, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wdata, output int lat);
        int bytes, off, a;
        logic [63:0] val, fmask;
        logic [7:0] sel;
        bytes = 1 << size;
        a     = int'(addr);
        off   = a % 4;
        if (bytes > 4 || (a % bytes) != 0) begin
            rspq.push_back('{rdata: 64'd0, err: 1'b1});
            lat = 1;
        end else begin
            sel = 8'(((1 << bytes) - 1) << off);
            if (we) begin
                ramq.push_back('{we: 1'b1, waddr: 32'(a / 4), sel: sel,
                                 wdata: 64'(32'(wdata << (8 * off)))});
                for (int i = 0; i < bytes; i++) refmem[a + i] = wdata[8*i +: 8];
                rspq.push_back('{rdata: 64'd0, err: 1'b0});
                lat = 2;
            end else begin
                val = 64'd0;
                for (int i = 0; i < bytes; i++) val = val | (64'(get_ref(a + i)) << (8 * i));
                fmask = (64'd1 << (8 * bytes)) - 64'd1;
                if (!uns && val[8*bytes-1]) val = val | (~fmask & 64'hFFFF_FFFF);
                ramq.push_back('{we: 1'b0, waddr: 32'(a / 4), sel: sel, wdata: 64'd0});
                rspq.push_back('{rdata: val, err: 1'b0});
                lat = RL + 2;
            end
        end
    endtask

    // RAM-side monitor: every strobe must match the next expected access.
    initial begin
        forever begin
            @(negedge clk);
            if (ram_en) begin
                if (ramq.size() == 0) begin
                    check("ram_unexpected", 64'd1, 64'd0);
                end else begin
                    ram_exp_t e;
                    e = ramq.pop_front();
                    check("ram_we", 64'(ram_we), 64'(e.we));
                    check("ram_addr", 64'(ram_addr), 64'(e.waddr));
                    check("ram_sel", 64'(ram_sel), 64'(e.sel));
                    if (e.we) check("ram_wdata", 64'(ram_wdata), e.wdata);
                end
            end
        end
    end

    // Response monitor: compares every cycle the response is shown, pops on handshake.
    initial begin
        forever begin
            @(negedge clk);
            if (rsp_valid) begin
                if (rspq.size() == 0) begin
                    check("rsp_unexpected", 64'd1, 64'd0);
                end else begin
                    check("rsp_rdata", 64'(rsp_rdata), rspq[0].rdata);
                    check("rsp_err", 64'(rsp_err), 64'(rspq[0].err));
                    if (rsp_ready) void'(rspq.pop_front());
                end
            end
        end
    end

    initial begin
        rsp_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            rsp_ready = hold_rsp ? 1'b0 : ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic issue32(input logic we, input logic [1:0] size, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wdata, input int stall,
                           output logic [31:0] rdata, output logic err);
        int lat, n, t;
        model32(we, size, uns, addr, wdata, lat);
        if (stall > 0) hold_rsp = 1'b1;
        req_we = we; req_size = size; req_unsigned = uns; req_addr = addr; req_wdata = wdata;
        req_valid = 1'b1;
        t = 0;
        do begin @(negedge clk); t++; end while (!req_ready && t < 50);
        if (!req_ready) begin
            check("accept_timeout", 64'd0, 64'd1);
            req_valid = 1'b0; hold_rsp = 1'b0; rdata = '0; err = 1'b1;
            return;
        end
        @(posedge clk); #1;
        req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom;
        n = 0;
        do begin @(negedge clk); n++; end while (!rsp_valid && n < 20);
        check("latency", 64'(n), 64'(lat));
        if (stall > 0) begin
            req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_addr = 32'h40;
            for (int i = 0; i < stall; i++) begin
                check("busy_req_ready", 64'(req_ready), 64'd0);
                check("busy_rsp_valid", 64'(rsp_valid), 64'd1);
                @(negedge clk);
            end
            req_valid = 1'b0;
            hold_rsp = 1'b0;
        end
        t = 0;
        while (!(rsp_valid && rsp_ready) && t < 100) begin @(negedge clk); t++; end
        if (!(rsp_valid && rsp_ready)) check("rsp_timeout", 64'd0, 64'd1);
        rdata = rsp_rdata; err = rsp_err;
        @(posedge clk); #1;
    endtask

    task automatic issue64(input logic we, input logic [1:0] size, input logic uns,
                           input logic [31:0] addr, input logic [63:0] wdata,
                           output logic [63:0] rdata, output logic err,
                           output logic [31:0] en_addr, output logic [7:0] en_sel,
                           output logic [63:0] en_wdata, output int en_cnt);
        int n, t;
        en_addr = '0; en_sel = '0; en_wdata = '0; en_cnt = 0;
        b_req_we = we; b_req_size = size; b_req_unsigned = uns; b_req_addr = addr;
        b_req_wdata = wdata; b_req_valid = 1'b1;
        t = 0;
        do begin @(negedge clk); t++; end while (!b_req_ready && t < 50);
        if (!b_req_ready) check("accept64_timeout", 64'd0, 64'd1);
        @(posedge clk); #1;
        b_req_valid = 1'b0;
        n = 0;
        do begin
            @(negedge clk); n++;
            if (b_ram_en) begin
                en_cnt++; en_addr = b_ram_addr; en_sel = b_ram_sel; en_wdata = b_ram_wdata;
            end
        end while (!b_rsp_valid && n < 20);
        if (!b_rsp_valid) check("rsp64_timeout", 64'd0, 64'd1);
        rdata = b_rsp_rdata; err = b_rsp_err;
        @(posedge clk); #1;
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        logic [63:0] rd64, wd64;
        logic [31:0] ea;
        logic [7:0]  es;
        int          ec, lat_unused;

        rst_n = 1'b0;
        req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
        req_addr = '0; req_wdata = '0;
        b_req_valid = 1'b0; b_req_we = 1'b0; b_req_size = 2'b00; b_req_unsigned = 1'b0;
        b_req_addr = '0; b_req_wdata = '0; b_rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_req_ready", 64'(req_ready), 64'd1);
        check("rst_ram_en", 64'(ram_en), 64'd0);
        check("rst_ram_we", 64'(ram_we), 64'd0);
        check("rst_ram_addr", 64'(ram_addr), 64'd0);
        check("rst_ram_sel", 64'(ram_sel), 64'd0);
        check("rst_ram_wdata", 64'(ram_wdata), 64'd0);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
        check("rst_rsp_err", 64'(rsp_err), 64'd0);
        check("rst64_req_ready", 64'(b_req_ready), 64'd1);
        check("rst64_rsp_valid", 64'(b_rsp_valid), 64'd0);
        @(posedge clk); #1;

        // Directed cases on the 32-bit unit
        issue32(1'b1, 2'b00, 1'b0, 32'h1003, 32'h0000_00A5, 0, rd, er);
        check("sb_err", 64'(er), 64'd0);
        issue32(1'b1, 2'b10, 1'b0, 32'h2000, 32'h8001_7FFF, 0, rd, er);
        issue32(1'b0, 2'b01, 1'b0, 32'h2002, 32'h0, 0, rd, er);
        check("lh_signed", 64'(rd), 64'hFFFF_8001);
        issue32(1'b0, 2'b01, 1'b1, 32'h2002, 32'h0, 0, rd, er);
        check("lhu", 64'(rd), 64'h0000_8001);
        issue32(1'b1, 2'b10, 1'b0, 32'h3002, 32'h1234_5678, 0, rd, er);
        check("sw_misaligned_err", 64'(er), 64'd1);
        check("sw_misaligned_rdata", 64'(rd), 64'd0);
        issue32(1'b0, 2'b11, 1'b0, 32'h3000, 32'h0, 0, rd, er);
        check("size11_err", 64'(er), 64'd1);
        issue32(1'b0, 2'b10, 1'b0, 32'h2000, 32'h0, 5, rd, er);
        check("stall_lw", 64'(rd), 64'h8001_7FFF);

        // Reset while the load is waiting on the RAM
        model32(1'b0, 2'b10, 1'b0, 32'h2000, 32'h0, lat_unused);
        req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0; req_addr = 32'h2000;
        req_valid = 1'b1;
        @(negedge clk);
        check("pre_reset_ready", 64'(req_ready), 64'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        void'(rspq.pop_back());
        @(negedge clk);
        check("wait_reset_ready", 64'(req_ready), 64'd1);
        check("wait_reset_rsp_valid", 64'(rsp_valid), 64'd0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("no_late_rsp", 64'(rsp_valid), 64'd0);
        end
        @(posedge clk); #1;

        // Randomized traffic on the 32-bit unit
        for (int k = 0; k < 200; k++) begin
            logic        we, uns;
            logic [1:0]  sz;
            logic [31:0] a;
            we  = 1'($urandom_range(0, 1));
            uns = 1'($urandom_range(0, 1));
            sz  = 2'($urandom_range(0, 3));
            a   = 32'h100 + 32'($urandom_range(0, 63));
            if ($urandom_range(0, 3) != 0) a = a & ~((32'd1 << sz) - 32'd1);
            issue32(we, sz, uns, a, $urandom, 0, rd, er);
            if ($urandom_range(0, 2) == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
        end

        // Directed cases on the 64-bit unit
        wd64 = 64'h1122_3344_5566_7788;
        issue64(1'b1, 2'b11, 1'b0, 32'h08, wd64, rd64, er, ea, es, rd64, ec);
        check("sd_ram_addr", 64'(ea), 64'h1);
        check("sd_ram_sel", 64'(es), 64'hFF);
        check("sd_ram_wdata", rd64, wd64);
        check("sd_en_cnt", 64'(ec), 64'd1);
        check("sd_err", 64'(er), 64'd0);
        issue64(1'b0, 2'b11, 1'b0, 32'h08, 64'd0, rd64, er, ea, es, wd64, ec);
        check("ld", rd64, 64'h1122_3344_5566_7788);
        issue64(1'b0, 2'b00, 1'b0, 32'h08, 64'd0, rd64, er, ea, es, wd64, ec);
        check("lb_signed64", rd64, 64'hFFFF_FFFF_FFFF_FF88);
        issue64(1'b0, 2'b10, 1'b1, 32'h08, 64'd0, rd64, er, ea, es, wd64, ec);
        check("lwu64", rd64, 64'h0000_0000_5566_7788);
        issue64(1'b0, 2'b10, 1'b0, 32'h0C, 64'd0, rd64, er, ea, es, wd64, ec);
        check("lw_hi64", rd64, 64'h0000_0000_1122_3344);
        check("lw_hi64_sel", 64'(es), 64'hF0);
        issue64(1'b0, 2'b01, 1'b0, 32'h0E, 64'd0, rd64, er, ea, es, wd64, ec);
        check("lh_top64", rd64, 64'h0000_0000_0000_1122);
        issue64(1'b1, 2'b00, 1'b0, 32'h0F, 64'hF0, rd64, er, ea, es, wd64, ec);
        check("sb64_sel", 64'(es), 64'h80);
        check("sb64_wdata", wd64, 64'hF000_0000_0000_0000);
        issue64(1'b0, 2'b00, 1'b0, 32'h0F, 64'd0, rd64, er, ea, es, wd64, ec);
        check("lb64_signed", rd64, 64'hFFFF_FFFF_FFFF_FFF0);
        issue64(1'b0, 2'b11, 1'b0, 32'h0C, 64'd0, rd64, er, ea, es, wd64, ec);
        check("ld_misaligned_err", 64'(er), 64'd1);
        check("ld_misaligned_no_ram", 64'(ec), 64'd0);

        repeat (5) @(posedge clk);
        check("rspq_drained", 64'(rspq.size()), 64'd0);
        check("ramq_drained", 64'(ramq.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
